// File: rtl/alien_pkg.sv
// ---------------------------------------------------------------------------
// alien_pkg
//   Constants and types shared by the alien motion controller and the sprite
//   renderer.
//   - state_e     : motion FSM states (IDLE, MARCH, DROP, LANDED)
//   - AV_X/AV_Y   : active video size in pixels
//   - SPRITE_W/H  : alien sprite size in pixels
//   - POS_W       : width of the position outputs
//   - CMP_W       : width used for edge compares (one bit of headroom)
//   - div_width() : counter width able to hold a frame divide value
// ---------------------------------------------------------------------------
package alien_pkg;

  localparam int AV_X     = 640;
  localparam int AV_Y     = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  localparam int POS_W = 10;
  localparam int CMP_W = POS_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARCH  = 2'd1,
    DROP   = 2'd2,
    LANDED = 2'd3
  } state_e;

  // Bits needed to hold the value n itself (the divider limit input), min 1.
  function automatic int div_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_step_div.sv
// ---------------------------------------------------------------------------
// frame_step_div
//   Counts frame ticks and fires a one-cycle step every limit_i ticks.
//   Ports:
//     clk_i    : clock
//     reset_i  : synchronous active-high reset (count -> 0)
//     clear_i  : synchronous clear; also suppresses a coincident step
//     en_i     : count enable; when low the count is held
//     tick_i   : frame tick pulse
//     limit_i  : ticks per step (>= 1)
//     step_o   : combinational step pulse, high on the tick that wraps
// ---------------------------------------------------------------------------
module frame_step_div #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             step_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == limit_i - CNT_W'(1));
  assign step_o  = en_i & tick_i & at_last & ~clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (en_i && tick_i)
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alien_motion_ctrl.sv
// ---------------------------------------------------------------------------
// alien_motion_ctrl
//   Marching-invader position generator. Moves the sprite STEP_X pixels per
//   motion step; at a screen edge it spends one step entering DROP, the next
//   step drops STEP_Y pixels and reverses direction. When a drop would push
//   the sprite bottom past AV_Y it parks in LANDED. Position only changes on
//   frame_tick, so the renderer never sees a mid-frame move.
//   Ports:
//     clk          : clock
//     reset        : synchronous active-high reset
//     enable       : 1 = motion allowed, 0 = freeze position and divider
//     restart      : pulse; back to X0,Y0 and resume (IDLE if enable=0)
//     frame_tick   : pulse at start of vertical blank
//     alien_x/y    : registered sprite top-left position
//     moving_right : current horizontal direction
//     landed       : sprite bottom has reached the floor
//   Build option:
//     ALIEN_MOTION_SPEEDUP_EN : each successful drop shortens the step
//       interval by one frame (floor 1 frame).
// ---------------------------------------------------------------------------
module alien_motion_ctrl #(
  parameter int X0        = 32,
  parameter int Y0        = 32,
  parameter int AV_X      = alien_pkg::AV_X,
  parameter int AV_Y      = alien_pkg::AV_Y,
  parameter int SPRITE_W  = alien_pkg::SPRITE_W,
  parameter int SPRITE_H  = alien_pkg::SPRITE_H,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 16,
  parameter int FRAME_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       restart,
  input  logic                       frame_tick,
  output logic [alien_pkg::POS_W-1:0] alien_x,
  output logic [alien_pkg::POS_W-1:0] alien_y,
  output logic                       moving_right,
  output logic                       landed
);

  import alien_pkg::*;

  localparam int CNT_W = div_width(FRAME_DIV);

  // Edge thresholds in the widened compare domain so sums never wrap.
  localparam logic [CMP_W-1:0] RIGHT_SPAN = CMP_W'(SPRITE_W + STEP_X);
  localparam logic [CMP_W-1:0] DROP_SPAN  = CMP_W'(SPRITE_H + STEP_Y);
  localparam logic [CMP_W-1:0] LIM_X      = CMP_W'(AV_X);
  localparam logic [CMP_W-1:0] LIM_Y      = CMP_W'(AV_Y);
  localparam logic [CMP_W-1:0] STEP_X_C   = CMP_W'(STEP_X);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   x_q, x_d, y_q, y_d;
  logic               right_q, right_d;
  logic               landed_q, landed_d;

  logic               div_en;
  logic               step;
  logic [CNT_W-1:0]   div_limit;
  logic [CMP_W-1:0]   x_w, y_w;
  logic               hit_edge, hit_floor;

  // -------------------------------------------------------------------------
  // Frame divider: only runs while actually marching or dropping.
  // -------------------------------------------------------------------------
  assign div_en = enable & ((state_q == MARCH) | (state_q == DROP));

  frame_step_div #(.CNT_W(CNT_W)) u_div (
    .clk_i   (clk),
    .reset_i (reset),
    .clear_i (restart),
    .en_i    (div_en),
    .tick_i  (frame_tick),
    .limit_i (div_limit),
    .step_o  (step)
  );

`ifdef ALIEN_MOTION_SPEEDUP_EN
  // Step interval shrinks by one frame on every completed drop.
  logic [CNT_W-1:0] eff_div_q, eff_div_d;
  logic             drop_ok;

  assign drop_ok   = step & (state_q == DROP) & ~hit_floor;
  assign div_limit = eff_div_q;

  always_comb begin
    eff_div_d = eff_div_q;
    if (drop_ok && (eff_div_q > CNT_W'(1)))
      eff_div_d = eff_div_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || restart) eff_div_q <= CNT_W'(FRAME_DIV);
    else                  eff_div_q <= eff_div_d;
  end
`else
  assign div_limit = CNT_W'(FRAME_DIV);
`endif

  // -------------------------------------------------------------------------
  // Boundary tests
  // -------------------------------------------------------------------------
  assign x_w = {1'b0, x_q};
  assign y_w = {1'b0, y_q};

  // Right: next step would put the sprite's right edge past the screen.
  // Left:  next step would go below x=0.
  assign hit_edge  = right_q ? (x_w + RIGHT_SPAN > LIM_X) : (x_w < STEP_X_C);
  assign hit_floor = (y_w + DROP_SPAN > LIM_Y);

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= POS_W'(X0);
      y_q      <= POS_W'(Y0);
      right_q  <= 1'b1;
      landed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      right_q  <= right_d;
      landed_q <= landed_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state. A restart wins over anything the current state wants.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = enable ? MARCH : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = MARCH;
        MARCH:   if (step && hit_edge) state_d = DROP;
        DROP:    if (step) state_d = hit_floor ? LANDED : MARCH;
        LANDED:  state_d = LANDED;
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Position / direction / landed updates. step is already suppressed when a
  // restart is present, so a coincident tick never moves the sprite.
  // -------------------------------------------------------------------------
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    right_d  = right_q;
    landed_d = landed_q;
    if (restart) begin
      x_d      = POS_W'(X0);
      y_d      = POS_W'(Y0);
      right_d  = 1'b1;
      landed_d = 1'b0;
    end else if (step) begin
      case (state_q)
        MARCH: begin
          if (!hit_edge)
            x_d = right_q ? x_q + POS_W'(STEP_X) : x_q - POS_W'(STEP_X);
        end
        DROP: begin
          if (hit_floor) begin
            landed_d = 1'b1;
          end else begin
            y_d     = y_q + POS_W'(STEP_Y);
            right_d = ~right_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign alien_x      = x_q;
  assign alien_y      = y_q;
  assign moving_right = right_q;
  assign landed       = landed_q;

endmodule

// File: tb/tb_alien_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alien_motion_ctrl
//   Directed and randomized stimulus against a behavioural model of the
//   marching rules. The model tracks the sprite as plain integers and a
//   phase name; every clock the DUT outputs are compared to it, with extra
//   constant checks at the milestones of interest.
// ---------------------------------------------------------------------------
module tb_alien_motion_ctrl;

  localparam int X0 = 32, Y0 = 32, AVX = 640, AVY = 480;
  localparam int SW = 32, SH = 32, SX = 2, SY = 16, FD = 4;

  logic       clk = 1'b0;
  logic       reset, enable, restart, frame_tick;
  logic [9:0] alien_x, alien_y;
  logic       moving_right, landed;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int    mx, my, mcnt, meff;
  bit    mright, mland;
  string mphase;

  alien_motion_ctrl #(
    .X0(X0), .Y0(Y0), .AV_X(AVX), .AV_Y(AVY), .SPRITE_W(SW), .SPRITE_H(SH),
    .STEP_X(SX), .STEP_Y(SY), .FRAME_DIV(FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .restart      (restart),
    .frame_tick   (frame_tick),
    .alien_x      (alien_x),
    .alien_y      (alien_y),
    .moving_right (moving_right),
    .landed       (landed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_home();
    mx = X0; my = Y0; mright = 1; mland = 0; mcnt = 0; meff = FD;
  endtask

  // One motion step applied to the model.
  task automatic model_step();
    int nx;
    if (mphase == "MARCH") begin
      nx = mright ? mx + SX : mx - SX;
      if (nx < 0 || nx + SW > AVX) mphase = "DROP";
      else                         mx = nx;
    end else begin
      if (my + SY + SH > AVY) begin
        mphase = "LANDED";
        mland  = 1;
      end else begin
        my     = my + SY;
        mright = !mright;
        mphase = "MARCH";
`ifdef ALIEN_MOTION_SPEEDUP_EN
        if (meff > 1) meff = meff - 1;
`endif
      end
    end
  endtask

  task automatic model_clk(input bit r, input bit rs, input bit e, input bit t);
    if (r) begin
      model_home();
      mphase = "IDLE";
    end else if (rs) begin
      model_home();
      mphase = e ? "MARCH" : "IDLE";
    end else if (mphase == "IDLE") begin
      if (e) mphase = "MARCH";
    end else if (mphase != "LANDED" && e && t) begin
      mcnt = mcnt + 1;
      if (mcnt >= meff) begin
        mcnt = 0;
        model_step();
      end
    end
  endtask

  // Drive one clock of inputs, advance the model, compare all outputs.
  task automatic cyc(input bit r, input bit rs, input bit e, input bit t);
    reset = r; restart = rs; enable = e; frame_tick = t;
    @(posedge clk);
    model_clk(r, rs, e, t);
    #1;
    chk("track", {10'd0, alien_x, alien_y, moving_right, landed},
                 {10'd0, mx[9:0], my[9:0], mright, mland});
  endtask

  initial begin
    int n;
    bit rs, e, t;
    reset = 1; restart = 0; enable = 0; frame_tick = 0;
    model_home();
    mphase = "IDLE";

    // reset values
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_x", alien_x, 32);
    chk("rst_y", alien_y, 32);
    chk("rst_dir", moving_right, 1);
    chk("rst_landed", landed, 0);

    // first step lands after the 4th tick
    cyc(0, 0, 1, 0);
    repeat (3) cyc(0, 0, 1, 1);
    chk("pre_step_x", alien_x, 32);
    cyc(0, 0, 1, 1);
    chk("first_step_x", alien_x, 34);
    chk("first_step_y", alien_y, 32);

    // march to the right edge, drop, reverse
    n = 0;
    while (mx != 608 && n < 5000) begin cyc(0, 0, 1, 1); n++; end
    chk("reach_608", alien_x, 608);
    repeat (4) cyc(0, 0, 1, 1);
    chk("edge_hold_x", alien_x, 608);
    chk("edge_hold_y", alien_y, 32);
    repeat (4) cyc(0, 0, 1, 1);
    chk("drop_y", alien_y, 48);
    chk("drop_dir", moving_right, 0);
    repeat (4) cyc(0, 0, 1, 1);
    chk("left_x", alien_x, 606);

    // freeze mid-count, then resume with the remaining ticks
    repeat (2) cyc(0, 0, 1, 1);
    repeat (10) cyc(0, 0, 0, 1);
    chk("freeze_x", alien_x, 606);
    chk("freeze_y", alien_y, 48);
    cyc(0, 0, 1, 1);
    chk("resume_pre_x", alien_x, 606);
    cyc(0, 0, 1, 1);
    chk("resume_step_x", alien_x, 604);

    // randomized mix of enable, ticks and occasional restarts
    repeat (600) begin
      rs = ($urandom_range(0, 99) < 2);
      e  = ($urandom_range(0, 99) < 85);
      t  = ($urandom_range(0, 1) == 1);
      cyc(0, rs, e, t);
    end

    // march all the way down to the floor
    cyc(0, 1, 1, 0);
    n = 0;
    while (!mland && n < 40000) begin cyc(0, 0, 1, 1); n++; end
    chk("landed_flag", landed, 1);
    chk("landed_y", alien_y, 448);
    repeat (20) cyc(0, 0, 1, 1);
    chk("landed_hold_y", alien_y, 448);
    chk("landed_hold_x", alien_x, mx);
    cyc(0, 1, 1, 0);
    chk("restart_x", alien_x, 32);
    chk("restart_y", alien_y, 32);
    chk("restart_landed", landed, 0);
    chk("restart_dir", moving_right, 1);

    // restart coinciding with a step-issuing tick discards the step
    repeat (3) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    chk("collide_x", alien_x, 32);
    repeat (3) cyc(0, 0, 1, 1);
    chk("collide_cnt_x", alien_x, 32);
    cyc(0, 0, 1, 1);
    chk("collide_next_x", alien_x, 34);

    // reset while in DROP
    n = 0;
    while (mphase != "DROP" && n < 5000) begin cyc(0, 0, 1, 1); n++; end
    chk("in_drop_x", alien_x, 608);
    repeat (2) cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    chk("drop_rst_x", alien_x, 32);
    chk("drop_rst_y", alien_y, 32);
    chk("drop_rst_dir", moving_right, 1);
    chk("drop_rst_landed", landed, 0);
    cyc(0, 0, 1, 0);
    repeat (4) cyc(0, 0, 1, 1);
    chk("post_rst_x", alien_x, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
